// File: rtl/imem_instr_responder.sv
// ============================================================================
// Module      : imem_instr_responder
// Description : Instruction-memory stand-in for a core's fetch port. Accepts
//               one fetch at a time, waits a configurable latency, then
//               returns a pseudo-random I-type ALU or byte-load instruction
//               drawn from a 32-bit LFSR. A number of leading responses after
//               reset are forced to NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_instr_responder #(
    parameter logic [31:0] SEED      = 32'h000117E4,
    parameter int          LATENCY   = 1,
    parameter int          NOP_COUNT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_imem_req_valid,
    output logic        io_imem_req_ready,
    input  logic [31:0] io_imem_req_bits_addr,
    output logic        io_imem_resp_valid,
    input  logic        io_imem_resp_ready,
    output logic [31:0] io_imem_resp_bits_data,
    output logic [31:0] resp_addr,
    output logic [31:0] issued_count
);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] c_SEED     = (SEED == 32'h0) ? 32'h00000001 : SEED;
    // Latency is clamped into the counter's representable range.
    localparam int          c_LAT      = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
    localparam logic [3:0]  c_LAT_INIT = 4'(c_LAT - 1);
    localparam logic [32:0] c_NOP_CNT  = 33'(NOP_COUNT);
    localparam logic [31:0] c_NOP_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_data;
    logic [31:0] r_addr;
    logic [31:0] r_count;
    logic [31:0] r_lfsr;
    logic [3:0]  r_lat;

    logic [31:0] w_lfsr_next;
    logic        w_choice;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [11:0] w_imm;
    logic        w_nop;
    logic [31:0] w_word;

    // Next LFSR value and the instruction decoded from it.
    always_comb begin
        w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
        w_choice    = w_lfsr_next[0];
        w_f3        = w_lfsr_next[3:1];
        w_rd        = w_lfsr_next[8:4];
        w_rs1       = w_lfsr_next[13:9];
        w_imm       = w_lfsr_next[25:14];
        // Shift immediates keep only legal shamt bits (plus the SRAI flag).
        if (w_f3 == 3'd5) begin
            w_imm = w_imm & 12'h41F;
        end else if (w_f3 == 3'd1) begin
            w_imm = w_imm & 12'h01F;
        end
        // count < NOP_COUNT written as count+1 <= NOP_COUNT so NOP_COUNT=0 is not a constant compare.
        w_nop = (({1'b0, r_count} + 33'd1) <= c_NOP_CNT);
        if (w_nop) begin
            w_word = c_NOP_WORD;
        end else if (w_choice) begin
            w_word = {w_imm, w_rs1, w_f3, w_rd, 7'b0010011};
        end else begin
            // Loads are restricted to LB/LBU.
            w_word = {w_imm, w_rs1, w_f3 & 3'b100, w_rd, 7'b0000011};
        end
    end

    // Fetch handshake FSM with registered ready/valid outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_data       <= c_NOP_WORD;
            r_addr       <= 32'h0;
            r_count      <= 32'h0;
            r_lfsr       <= c_SEED;
            r_lat        <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_imem_req_valid && r_req_ready) begin
                        r_addr      <= io_imem_req_bits_addr;
                        r_lat       <= c_LAT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat == 4'h0) begin
                        r_lfsr       <= w_lfsr_next;
                        r_data       <= w_word;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_lat <= r_lat - 4'h1;
                    end
                end
                S_RESP: begin
                    if (io_imem_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_count      <= r_count + 32'h1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_imem_req_ready      = r_req_ready;
    assign io_imem_resp_valid     = r_resp_valid;
    assign io_imem_resp_bits_data = r_data;
    assign resp_addr              = r_addr;
    assign issued_count           = r_count;

endmodule

`default_nettype wire
